// File: rtl/qed_dup_scheduler.sv
// QED duplicate scheduler: issues originals, then their register-shifted
// duplicates from an 8-entry FIFO, in order, ahead of the fetch stage.
module qed_dup_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        exec_dup,
  input  logic        stall_IF,
  input  logic [31:0] ifu_qed_instruction,
  output logic [31:0] qed_instruction,
  output logic        qed_vld_out,
  output logic        qed_ifu_stall,
  output logic        qed_ready,
  output logic [7:0]  num_orig,
  output logic [7:0]  num_dup
);

  localparam logic [0:0]  ORIG = 1'b0;
  localparam logic [0:0]  DUP  = 1'b1;
  localparam logic [31:0] NOP  = 32'h0000_007F;

  logic [31:0] fifo_q [8];
  logic [2:0]  wr_q;
  logic [2:0]  rd_q;
  logic [3:0]  cnt_q;
  logic [0:0]  state_q;
  logic [7:0]  norig_q;
  logic [7:0]  ndup_q;
  logic [31:0] ins_q;
  logic        vld_q;

  logic        empty;
  logic        full;
  logic        dup_go;
  logic        in_rec;
  logic [31:0] head;
  logic [31:0] head_mask;

  // Duplicate mask: sets bit 4 of the shifted register fields
  // (x0-x15 -> x16-x31) and bit 7 of the memory offset.
  // Zero means the instruction is not duplicated.
  function automatic logic [31:0] dup_mask(input logic [31:0] ins);
    logic [6:0]  op;
    logic        f3w;
    logic [31:0] m;
    op  = ins[6:0];
    f3w = (ins[14:12] == 3'b010);
    m   = '0;
    unique case (1'b1)
      (op == 7'h33):        m = 32'h0108_0800;
      (op == 7'h13):        m = 32'h0008_0800;
      (op == 7'h03) && f3w: m = 32'h0800_0800;
      (op == 7'h23) && f3w: m = 32'h0808_0000;
      default:              m = '0;
    endcase
    return m;
  endfunction

  assign empty     = (cnt_q == 4'd0);
  assign full      = (cnt_q == 4'd8);
  assign head      = fifo_q[rd_q];
  assign head_mask = dup_mask(head);
  assign in_rec    = (dup_mask(ifu_qed_instruction) != 32'd0);

  assign dup_go = (state_q == DUP)
                | (exec_dup & ~empty)
                | full
                | (norig_q == 8'hFF);

  assign qed_ifu_stall = stall_IF | (ena & dup_go);
  assign qed_ready     = ena & empty
                       & (norig_q == ndup_q)
                       & (norig_q != 8'd0);

  assign qed_instruction = ins_q;
  assign qed_vld_out     = vld_q;
  assign num_orig        = norig_q;
  assign num_dup         = ndup_q;

  // Issue register, FIFO, counters and ORIG/DUP state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) fifo_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      state_q <= ORIG;
      norig_q <= '0;
      ndup_q  <= '0;
      ins_q   <= NOP;
      vld_q   <= 1'b0;
    end else if (!ena) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      state_q <= ORIG;
      norig_q <= '0;
      ndup_q  <= '0;
      if (!stall_IF) begin
        ins_q <= ifu_qed_instruction;
        vld_q <= 1'b1;
      end
    end else if (!stall_IF) begin
      if (dup_go) begin
        if (!empty) begin
          ins_q   <= head | head_mask;
          vld_q   <= 1'b1;
          rd_q    <= rd_q + 3'd1;
          cnt_q   <= cnt_q - 4'd1;
          ndup_q  <= ndup_q + 8'd1;
          state_q <= (cnt_q == 4'd1) ? ORIG : DUP;
        end else begin
          // Originals exhausted at 255 and nothing left to duplicate.
          vld_q <= 1'b0;
        end
      end else begin
        ins_q <= ifu_qed_instruction;
        vld_q <= 1'b1;
        if (in_rec) begin
          fifo_q[wr_q] <= ifu_qed_instruction;
          wr_q    <= wr_q + 3'd1;
          cnt_q   <= cnt_q + 4'd1;
          norig_q <= norig_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Bench for qed_dup_scheduler: directed scenarios plus random traffic
// checked every cycle against a queue-based behavioural model.
module tb_qed_dup_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        exec_dup;
  logic        stall_IF;
  logic [31:0] ifu;
  logic [31:0] qed_instruction;
  logic        qed_vld_out;
  logic        qed_ifu_stall;
  logic        qed_ready;
  logic [7:0]  num_orig;
  logic [7:0]  num_dup;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  logic [31:0] mq [$];
  bit          m_dup;
  int          m_no;
  int          m_nd;
  logic [31:0] m_ins;
  bit          m_vld;

  qed_dup_scheduler dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ena                 (ena),
    .exec_dup            (exec_dup),
    .stall_IF            (stall_IF),
    .ifu_qed_instruction (ifu),
    .qed_instruction     (qed_instruction),
    .qed_vld_out         (qed_vld_out),
    .qed_ifu_stall       (qed_ifu_stall),
    .qed_ready           (qed_ready),
    .num_orig            (num_orig),
    .num_dup             (num_dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // 0 unrecognised, 1 R, 2 I, 3 LW, 4 SW
  function automatic int kind(input logic [31:0] i);
    if (i[6:0] == 7'h33) return 1;
    if (i[6:0] == 7'h13) return 2;
    if (i[6:0] == 7'h03 && i[14:12] == 3'b010) return 3;
    if (i[6:0] == 7'h23 && i[14:12] == 3'b010) return 4;
    return 0;
  endfunction

  // Duplicate built from fields: registers +16, offsets +128.
  function automatic logic [31:0] dupof(input logic [31:0] i);
    logic [31:0] r;
    logic [11:0] imm;
    r = i;
    case (kind(i))
      1: begin
        r[11:7]  = i[11:7] + 5'd16;
        r[19:15] = i[19:15] + 5'd16;
        r[24:20] = i[24:20] + 5'd16;
      end
      2: begin
        r[11:7]  = i[11:7] + 5'd16;
        r[19:15] = i[19:15] + 5'd16;
      end
      3: begin
        r[11:7]  = i[11:7] + 5'd16;
        r[31:20] = i[31:20] + 12'd128;
      end
      4: begin
        r[19:15] = i[19:15] + 5'd16;
        imm      = {i[31:25], i[11:7]} + 12'd128;
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      default: r = i;
    endcase
    return r;
  endfunction

  function automatic bit m_go();
    return m_dup || (exec_dup && mq.size() > 0)
        || mq.size() == 8 || m_no == 255;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_dup = 1'b0;
    m_no  = 0;
    m_nd  = 0;
    m_ins = 32'h0000_007F;
    m_vld = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] h;
    if (!rst_n) begin
      model_reset();
    end else if (!ena) begin
      mq.delete();
      m_dup = 1'b0;
      m_no  = 0;
      m_nd  = 0;
      if (!stall_IF) begin
        m_ins = ifu;
        m_vld = 1'b1;
      end
    end else if (!stall_IF) begin
      if (m_go()) begin
        if (mq.size() > 0) begin
          h     = mq.pop_front();
          m_ins = dupof(h);
          m_vld = 1'b1;
          m_nd++;
          m_dup = (mq.size() != 0);
        end else begin
          m_vld = 1'b0;
        end
      end else begin
        m_ins = ifu;
        m_vld = 1'b1;
        if (kind(ifu) != 0) begin
          mq.push_back(ifu);
          m_no++;
        end
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ins",   qed_instruction, m_ins);
      chk("vld",   {31'd0, qed_vld_out}, {31'd0, m_vld});
      chk("norig", {24'd0, num_orig}, m_no);
      chk("ndup",  {24'd0, num_dup}, m_nd);
      chk("stall", {31'd0, qed_ifu_stall},
          {31'd0, stall_IF | (ena & m_go())});
      chk("ready", {31'd0, qed_ready},
          {31'd0, ena && mq.size() == 0 && m_no == m_nd && m_no != 0});
    end
  end

  task automatic apply(input logic e, input logic x, input logic s,
                       input logic [31:0] i);
    ena      = e;
    exec_dup = x;
    stall_IF = s;
    ifu      = i;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [31:0] r;
    r = $urandom;
    r[11] = 1'b0;
    r[19] = 1'b0;
    r[24] = 1'b0;
    case ($urandom_range(0, 5))
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: begin r[6:0] = 7'h03; r[14:12] = 3'b010; r[27] = 1'b0; end
      3: begin r[6:0] = 7'h23; r[14:12] = 3'b010; r[27] = 1'b0; end
      4: r[6:0] = 7'h37;
      default: begin r[6:0] = 7'h03; r[14:12] = 3'b000; end
    endcase
    return r;
  endfunction

  localparam logic [31:0] ADD = 32'h0031_00B3;
  localparam logic [31:0] LW  = 32'h0000_2283;
  localparam logic [31:0] SW  = 32'h0001_A023;

  initial begin
    rst_n = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 32'd0);
    model_reset();
    chk_on = 1'b1;
    step();
    step();
    chk("rst_ins", qed_instruction, 32'h0000_007F);
    chk("rst_vld", {31'd0, qed_vld_out}, 32'd0);
    chk("rst_cnt", {num_orig, num_dup}, 16'd0);
    chk("rst_ready", {31'd0, qed_ready}, 32'd0);
    rst_n = 1'b1;

    // ADD original then its duplicate
    apply(1'b1, 1'b0, 1'b0, ADD);
    step();
    chk("add_ins", qed_instruction, ADD);
    chk("add_vld", {31'd0, qed_vld_out}, 32'd1);
    chk("add_norig", {24'd0, num_orig}, 32'd1);
    chk("add_ready", {31'd0, qed_ready}, 32'd0);
    apply(1'b1, 1'b1, 1'b0, ADD);
    #1 chk("add_dupstall", {31'd0, qed_ifu_stall}, 32'd1);
    step();
    chk("add_dup", qed_instruction, 32'h0139_08B3);
    chk("add_ndup", {24'd0, num_dup}, 32'd1);
    chk("add_dready", {31'd0, qed_ready}, 32'd1);
    apply(1'b1, 1'b0, 1'b0, ADD);
    #1 chk("add_orig_back", {31'd0, qed_ifu_stall}, 32'd0);

    // LW / SW duplicates in order
    apply(1'b1, 1'b0, 1'b0, LW);
    step();
    apply(1'b1, 1'b0, 1'b0, SW);
    step();
    apply(1'b1, 1'b1, 1'b0, 32'h0000_0013);
    step();
    chk("lw_dup", qed_instruction, 32'h0800_2A83);
    step();
    chk("sw_dup", qed_instruction, 32'h0809_A023);
    chk("lwsw_cnt", {num_orig, num_dup}, {8'd3, 8'd3});

    // ena low: pass-through, counters cleared
    apply(1'b0, 1'b0, 1'b0, 32'h1234_5678);
    step();
    chk("pass_ins", qed_instruction, 32'h1234_5678);
    chk("pass_cnt", {num_orig, num_dup}, 16'd0);

    // Fill the FIFO; the ninth cycle is forced into DUP
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 1'b0, {12'(i), 5'(i), 3'b000, 5'(i), 7'h13});
      step();
    end
    apply(1'b1, 1'b0, 1'b0, 32'h0010_0093);
    #1 chk("full_stall", {31'd0, qed_ifu_stall}, 32'd1);
    for (int j = 0; j < 8; j++) begin
      step();
      if (j == 0) chk("full_dup0", qed_instruction, 32'h0008_0813);
      if (j == 7) chk("full_dup7", qed_instruction, 32'h007B_8B93);
    end
    chk("full_cnt", {num_orig, num_dup}, {8'd8, 8'd8});
    chk("full_ready", {31'd0, qed_ready}, 32'd1);

    // Stall during DUP
    apply(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    apply(1'b1, 1'b0, 1'b0, ADD);
    step();
    apply(1'b1, 1'b0, 1'b0, LW);
    step();
    apply(1'b1, 1'b0, 1'b0, SW);
    step();
    apply(1'b1, 1'b1, 1'b0, 32'd0);
    step();
    chk("stl_dup0", qed_instruction, 32'h0139_08B3);
    apply(1'b1, 1'b0, 1'b1, 32'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("stl_hold", qed_instruction, 32'h0139_08B3);
      chk("stl_cnt", {num_orig, num_dup}, {8'd3, 8'd1});
    end
    apply(1'b1, 1'b0, 1'b0, 32'd0);
    step();
    chk("stl_dup1", qed_instruction, 32'h0800_2A83);
    step();
    chk("stl_dup2", qed_instruction, 32'h0809_A023);

    // Reset in the middle of DUP
    apply(1'b1, 1'b0, 1'b0, ADD);
    step();
    apply(1'b1, 1'b0, 1'b0, LW);
    step();
    apply(1'b1, 1'b1, 1'b0, SW);
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_ins", qed_instruction, 32'h0000_007F);
    chk("mrst_vld", {31'd0, qed_vld_out}, 32'd0);
    chk("mrst_cnt", {num_orig, num_dup}, 16'd0);
    step();
    rst_n = 1'b1;
    apply(1'b1, 1'b1, 1'b0, 32'h0010_0093);
    step();
    chk("mrst_orig", qed_instruction, 32'h0010_0093);
    chk("mrst_cnt2", {num_orig, num_dup}, {8'd1, 8'd0});

    // Original count saturation at 255
    apply(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    for (int j = 0; j < 530; j++) begin
      apply(1'b1, 1'b0, 1'b0, 32'h0000_0013);
      step();
    end
    chk("sat_cnt", {num_orig, num_dup}, {8'd255, 8'd255});
    chk("sat_vld", {31'd0, qed_vld_out}, 32'd0);

    // Random traffic
    for (int j = 0; j < 4000; j++) begin
      apply(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
            rnd_ins());
      if ($urandom_range(0, 999) < 3) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
